// File: rtl/qram_access_initiator_pkg.sv
// Shared definitions for the QRAM access initiator: FSM state and op encodings,
// default timing constants, and constant helpers for sizing counters.
package qram_access_initiator_pkg;

    // Default timing, in DDRClockP cycles.
    localparam int QRAM_SETUP_CYCLES  = 2;
    localparam int QRAM_STROBE_HALF   = 1;
    localparam int QRAM_CAPTURE_DELAY = 1;
    localparam int QRAM_HOLD_CYCLES   = 1;

    typedef enum logic [2:0] {
        QRAM_IDLE    = 3'd0,
        QRAM_SETUP   = 3'd1,
        QRAM_STROBE  = 3'd2,
        QRAM_HOLD    = 3'd3,
        QRAM_CAPTURE = 3'd4,
        QRAM_RESP    = 3'd5
    } qramState_e;

    typedef enum logic {
        QRAM_OP_READ  = 1'b0,
        QRAM_OP_WRITE = 1'b1
    } qramOp_e;

    // Largest of three timing parameters.
    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

    // Counter width able to hold maxVal; never narrower than one bit.
    function automatic int cntWidth(input int maxVal);
        if (maxVal <= 32'sd0) begin
            return 1;
        end else begin
            return $clog2(maxVal + 32'sd1);
        end
    endfunction

endpackage

// File: rtl/qram_access_initiator_if.sv
// Request/response handshake between the memory scheduler (master) and the
// QRAM access initiator (slave).
interface qram_access_initiator_if;
    logic ReqValid;
    logic ReqReady;
    logic ReqWrite;
    logic ReqAddr;
    logic ReqData;
    logic RspValid;
    logic RspReady;
    logic RspData;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqData, RspReady,
        input  ReqReady, RspValid, RspData
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqData, RspReady,
        output ReqReady, RspValid, RspData
    );
endinterface

// File: rtl/qram_access_initiator_strobe_gen.sv
// DDR strobe generator: on start, drives one full strobe period (high for
// STROBE_HALF cycles, then low for STROBE_HALF cycles) and flags done on the
// final low cycle. P and N are separate registers so the pair is glitch-free.
module qram_strobe_gen
    import qram_access_initiator_pkg::*;
#(
    parameter int STROBE_HALF = QRAM_STROBE_HALF
) (
    input  logic clk,
    input  logic Reset,
    input  logic start,
    output logic done,
    output logic DDRClockOutP,
    output logic DDRClockOutN
);

    localparam int CNT_W = cntWidth(STROBE_HALF);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(STROBE_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             active_r;
    logic             strobeP_r;
    logic             strobeN_r;
    logic [CNT_W-1:0] halfCnt_r;

    // Done is decoded from state so the FSM can leave STROBE on the same edge
    // that ends the low half-period.
    assign done         = active_r & ~strobeP_r & (halfCnt_r == HALF_LAST);
    assign DDRClockOutP = strobeP_r;
    assign DDRClockOutN = strobeN_r;

    // Strobe phase sequencing: high half, low half, then return to idle.
    always_ff @(posedge clk) begin
        if (Reset) begin
            active_r  <= 1'b0;
            strobeP_r <= 1'b0;
            strobeN_r <= 1'b1;
            halfCnt_r <= CNT_ZERO;
        end else if (start) begin
            active_r  <= 1'b1;
            strobeP_r <= 1'b1;
            strobeN_r <= 1'b0;
            halfCnt_r <= CNT_ZERO;
        end else if (active_r) begin
            if (halfCnt_r == HALF_LAST) begin
                halfCnt_r <= CNT_ZERO;
                if (strobeP_r) begin
                    strobeP_r <= 1'b0;
                    strobeN_r <= 1'b1;
                end else begin
                    active_r <= 1'b0;
                end
            end else begin
                halfCnt_r <= halfCnt_r + CNT_ONE;
            end
        end else begin
            strobeP_r <= 1'b0;
            strobeN_r <= 1'b1;
        end
    end

endmodule

// File: rtl/qram_access_initiator.sv
// Host-side initiator for one QRAM_inSDRAM cell. Takes one read or write on the
// request port, sequences SETUP / STROBE / HOLD / CAPTURE around a single DDR
// strobe period, and returns read data on the response port.
module qram_access_initiator
    import qram_access_initiator_pkg::*;
#(
    parameter int SETUP_CYCLES  = QRAM_SETUP_CYCLES,
    parameter int STROBE_HALF   = QRAM_STROBE_HALF,
    parameter int CAPTURE_DELAY = QRAM_CAPTURE_DELAY,
    parameter int HOLD_CYCLES   = QRAM_HOLD_CYCLES
) (
    input  logic                          DDRClockP,
    input  logic                          Reset,
    qram_access_initiator_if.slave        hostIf,
    output logic                          Busy,
    output logic                          Read,
    output logic                          Write,
    output logic                          AddressQBit,
    output logic                          inputQBit,
    output logic                          DDRClockOutP,
    output logic                          DDRClockOutN,
    input  logic                          outputQBit
);

    localparam int CNT_MAX = maxOf3(SETUP_CYCLES, HOLD_CYCLES, CAPTURE_DELAY);
    localparam int CNT_W   = cntWidth(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SETUP_CYCLES  > 32'sd0) ? SETUP_CYCLES  - 32'sd1 : 32'sd0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD_CYCLES   > 32'sd0) ? HOLD_CYCLES   - 32'sd1 : 32'sd0);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'((CAPTURE_DELAY > 32'sd0) ? CAPTURE_DELAY - 32'sd1 : 32'sd0);

    // A zero-length phase is skipped entirely rather than lasting one cycle.
    localparam bit SKIP_SETUP   = (SETUP_CYCLES  == 32'sd0);
    localparam bit SKIP_HOLD    = (HOLD_CYCLES   == 32'sd0);
    localparam bit SKIP_CAPTURE = (CAPTURE_DELAY == 32'sd0);

    qramState_e       state_r;
    qramOp_e          op_r;
    logic [CNT_W-1:0] cnt_r;
    logic             reqReady_r;
    logic             rspValid_r;
    logic             rspData_r;
    logic             busy_r;
    logic             read_r;
    logic             write_r;
    logic             addr_r;
    logic             data_r;

    logic             accept_s;
    logic             strobeStart_s;
    logic             strobeDone_s;
    logic             holdExit_s;

    assign hostIf.ReqReady = reqReady_r;
    assign hostIf.RspValid = rspValid_r;
    assign hostIf.RspData  = rspData_r;
    assign Busy            = busy_r;
    assign Read            = read_r;
    assign Write           = write_r;
    assign AddressQBit     = addr_r;
    assign inputQBit       = data_r;

    // ReqReady is only high in IDLE with no response pending.
    assign accept_s = hostIf.ReqValid & reqReady_r;

    // Launch the strobe on the edge that enters STROBE (straight from IDLE when SETUP is skipped).
    always_comb begin
        strobeStart_s = 1'b0;
        case (state_r)
            QRAM_IDLE: begin
                if (accept_s && SKIP_SETUP) begin
                    strobeStart_s = 1'b1;
                end else begin
                    strobeStart_s = 1'b0;
                end
            end
            QRAM_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    strobeStart_s = 1'b1;
                end else begin
                    strobeStart_s = 1'b0;
                end
            end
            default: strobeStart_s = 1'b0;
        endcase
    end

    // End of the hold window: Read/Write drop here (directly after STROBE when HOLD is skipped).
    always_comb begin
        holdExit_s = 1'b0;
        case (state_r)
            QRAM_STROBE: begin
                if (strobeDone_s && SKIP_HOLD) begin
                    holdExit_s = 1'b1;
                end else begin
                    holdExit_s = 1'b0;
                end
            end
            QRAM_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    holdExit_s = 1'b1;
                end else begin
                    holdExit_s = 1'b0;
                end
            end
            default: holdExit_s = 1'b0;
        endcase
    end

    qram_strobe_gen #(
        .STROBE_HALF (STROBE_HALF)
    ) strobeGen (
        .clk          (DDRClockP),
        .Reset        (Reset),
        .start        (strobeStart_s),
        .done         (strobeDone_s),
        .DDRClockOutP (DDRClockOutP),
        .DDRClockOutN (DDRClockOutN)
    );

    // Transaction FSM with all cell-facing and handshake outputs registered.
    always_ff @(posedge DDRClockP) begin
        if (Reset) begin
            state_r    <= QRAM_IDLE;
            op_r       <= QRAM_OP_READ;
            cnt_r      <= CNT_ZERO;
            reqReady_r <= 1'b1;
            rspValid_r <= 1'b0;
            rspData_r  <= 1'b0;
            busy_r     <= 1'b0;
            read_r     <= 1'b0;
            write_r    <= 1'b0;
            addr_r     <= 1'b0;
            data_r     <= 1'b0;
        end else begin
            case (state_r)
                QRAM_IDLE: begin
                    if (accept_s) begin
                        op_r       <= qramOp_e'(hostIf.ReqWrite);
                        addr_r     <= hostIf.ReqAddr;
                        data_r     <= hostIf.ReqData;
                        write_r    <= hostIf.ReqWrite;
                        read_r     <= ~hostIf.ReqWrite;
                        reqReady_r <= 1'b0;
                        busy_r     <= 1'b1;
                        cnt_r      <= CNT_ZERO;
                        state_r    <= SKIP_SETUP ? QRAM_STROBE : QRAM_SETUP;
                    end
                end
                QRAM_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= QRAM_STROBE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                QRAM_STROBE: begin
                    if (strobeDone_s && !SKIP_HOLD) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= QRAM_HOLD;
                    end
                end
                QRAM_HOLD: begin
                    if (cnt_r != HOLD_LAST) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                QRAM_CAPTURE: begin
                    if (cnt_r == CAP_LAST) begin
                        rspData_r  <= outputQBit;
                        rspValid_r <= 1'b1;
                        state_r    <= QRAM_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                QRAM_RESP: begin
                    if (hostIf.RspReady) begin
                        rspValid_r <= 1'b0;
                        reqReady_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= QRAM_IDLE;
                    end
                end
                default: begin
                    state_r    <= QRAM_IDLE;
                    read_r     <= 1'b0;
                    write_r    <= 1'b0;
                    rspValid_r <= 1'b0;
                    reqReady_r <= 1'b1;
                    busy_r     <= 1'b0;
                    cnt_r      <= CNT_ZERO;
                end
            endcase

            // Leaving the hold window overrides the per-state updates above.
            if (holdExit_s) begin
                read_r  <= 1'b0;
                write_r <= 1'b0;
                cnt_r   <= CNT_ZERO;
                if (op_r == QRAM_OP_WRITE) begin
                    state_r    <= QRAM_IDLE;
                    reqReady_r <= 1'b1;
                    busy_r     <= 1'b0;
                end else if (SKIP_CAPTURE) begin
                    rspData_r  <= outputQBit;
                    rspValid_r <= 1'b1;
                    state_r    <= QRAM_RESP;
                end else begin
                    state_r <= QRAM_CAPTURE;
                end
            end
        end
    end

endmodule

// File: tb/tb_qram_access_initiator.sv
// Directed bench for qram_access_initiator: a default-timing instance with a
// small cell model, and a STROBE_HALF=3 / SETUP_CYCLES=0 instance.
module tb_qram_access_initiator;
    import qram_access_initiator_pkg::*;

    logic DDRClockP = 1'b0;
    logic Reset;

    // Free-running clock.
    always #5 DDRClockP = ~DDRClockP;

    qram_access_initiator_if hostIf();
    qram_access_initiator_if hostIf6();

    logic busy, rd, wr, addrQ, dataQ, strobeP, strobeN;
    logic busy6, rd6, wr6, addrQ6, dataQ6, strobeP6, strobeN6;
    logic cellOut6 = 1'b0;

    logic [1:0] cellMem   = 2'b00;
    logic       cellOut   = 1'b0;
    logic       cellPrevP = 1'b0;

    qram_access_initiator dut (
        .DDRClockP(DDRClockP), .Reset(Reset), .hostIf(hostIf), .Busy(busy),
        .Read(rd), .Write(wr), .AddressQBit(addrQ), .inputQBit(dataQ),
        .DDRClockOutP(strobeP), .DDRClockOutN(strobeN), .outputQBit(cellOut)
    );

    qram_access_initiator #(
        .SETUP_CYCLES(0), .STROBE_HALF(3), .CAPTURE_DELAY(1), .HOLD_CYCLES(1)
    ) dut6 (
        .DDRClockP(DDRClockP), .Reset(Reset), .hostIf(hostIf6), .Busy(busy6),
        .Read(rd6), .Write(wr6), .AddressQBit(addrQ6), .inputQBit(dataQ6),
        .DDRClockOutP(strobeP6), .DDRClockOutN(strobeN6), .outputQBit(cellOut6)
    );

    // Cell model: acts on the rising strobe edge using the levels the initiator holds.
    always @(posedge DDRClockP) begin
        cellPrevP <= strobeP;
        if (strobeP && !cellPrevP) begin
            if (wr) cellMem[addrQ] <= dataQ;
            if (rd) cellOut <= cellMem[addrQ];
        end
    end

    int  nAssert, nFail;
    bit  expQ[$];
    bit  shadow[2];
    int  sWrite, sRead, sOverlap, sBadHold, sPHigh, sPRise, sRiseAt, sNBad;
    int  sRspCycles, sRspUnstable, sReadyInRsp, sRspCount, sRaisedAt, sReadyAt;
    logic sFirstRsp;
    bit  t5Wr[3], t5Addr[3], t5Data[3];
    int  accAt[3];

    task automatic chkBit(input string tag, input logic obs, input logic expv);
        nAssert++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s: observed %b required %b", tag, obs, expv);
        end
    endtask

    task automatic chkInt(input string tag, input int obs, input int expv);
        nAssert++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
    endtask

    task automatic popCheck(input string tag, input logic got);
        bit e;
        chkInt({tag, " pending"}, int'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            chkBit(tag, got, e);
        end
    endtask

    // One transaction on the default instance, called at a negedge with ReqReady=1.
    task automatic runTxn(input logic w, input logic a, input logic d, input int rspDelay);
        logic prevP;
        sWrite = 0; sRead = 0; sOverlap = 0; sBadHold = 0; sPHigh = 0; sPRise = 0;
        sRiseAt = 0; sNBad = 0; sRspCycles = 0; sRspUnstable = 0; sReadyInRsp = 0;
        sRspCount = 0; sRaisedAt = 0; sReadyAt = 0; sFirstRsp = 1'b0; prevP = 1'b0;
        hostIf.RspReady = 1'b0;
        hostIf.ReqWrite = w; hostIf.ReqAddr = a; hostIf.ReqData = d; hostIf.ReqValid = 1'b1;
        if (w) shadow[a] = d; else expQ.push_back(shadow[a]);
        @(negedge DDRClockP);
        hostIf.ReqValid = 1'b0; hostIf.ReqWrite = ~w; hostIf.ReqAddr = ~a; hostIf.ReqData = ~d;
        for (int i = 1; i <= 60; i++) begin
            if (wr) sWrite++;
            if (rd) sRead++;
            if (rd && wr) sOverlap++;
            if ((rd || wr) && (addrQ !== a || (w && dataQ !== d))) sBadHold++;
            if (strobeN !== ~strobeP) sNBad++;
            if (strobeP) begin
                sPHigh++;
                if (!prevP) sPRise++;
                if (sRiseAt == 0) sRiseAt = i;
            end
            prevP = strobeP;
            if (hostIf.RspValid) begin
                sRspCycles++;
                if (sRspCycles == 1) sFirstRsp = hostIf.RspData;
                else if (hostIf.RspData !== sFirstRsp) sRspUnstable++;
                if (hostIf.ReqReady) sReadyInRsp++;
                if (!hostIf.RspReady && sRspCycles > rspDelay) begin
                    hostIf.RspReady = 1'b1;
                    sRaisedAt = i;
                end
                if (hostIf.RspReady) begin
                    sRspCount++;
                    popCheck("rsp data", hostIf.RspData);
                end
            end
            if (hostIf.ReqReady) begin
                sReadyAt = i;
                break;
            end
            @(negedge DDRClockP);
        end
        hostIf.RspReady = 1'b0;
    endtask

    task automatic drive5(input int k);
        hostIf.ReqWrite = t5Wr[k]; hostIf.ReqAddr = t5Addr[k]; hostIf.ReqData = t5Data[k];
    endtask

    initial begin
        int seen, cnt, idx, acc, ovl, rspCnt, rise, hi, fall, wrc, ready;
        bit advance;
        nAssert = 0; nFail = 0;
        shadow[0] = 1'b0; shadow[1] = 1'b0;
        t5Wr = '{1'b1, 1'b0, 1'b1}; t5Addr = '{1'b0, 1'b0, 1'b1}; t5Data = '{1'b1, 1'b0, 1'b0};
        Reset = 1'b1;
        hostIf.ReqValid = 1'b0; hostIf.ReqWrite = 1'b0; hostIf.ReqAddr = 1'b0;
        hostIf.ReqData = 1'b0; hostIf.RspReady = 1'b0;
        hostIf6.ReqValid = 1'b0; hostIf6.ReqWrite = 1'b0; hostIf6.ReqAddr = 1'b0;
        hostIf6.ReqData = 1'b0; hostIf6.RspReady = 1'b1;
        repeat (3) @(negedge DDRClockP);

        // Reset state
        chkBit("rst Read", rd, 1'b0);           chkBit("rst Write", wr, 1'b0);
        chkBit("rst P", strobeP, 1'b0);         chkBit("rst N", strobeN, 1'b1);
        chkBit("rst ReqReady", hostIf.ReqReady, 1'b1);
        chkBit("rst RspValid", hostIf.RspValid, 1'b0);
        chkBit("rst RspData", hostIf.RspData, 1'b0);
        chkBit("rst Busy", busy, 1'b0);
        chkBit("rst Addr", addrQ, 1'b0);        chkBit("rst inQ", dataQ, 1'b0);
        chkBit("rst6 N", strobeN6, 1'b1);       chkBit("rst6 ReqReady", hostIf6.ReqReady, 1'b1);
        Reset = 1'b0;
        @(negedge DDRClockP);

        // Write addr=1 data=1
        runTxn(1'b1, 1'b1, 1'b1, 0);
        chkInt("wr Write cycles", sWrite, 5);   chkInt("wr Read cycles", sRead, 0);
        chkInt("wr strobe rises", sPRise, 1);   chkInt("wr strobe high", sPHigh, 1);
        chkInt("wr strobe rise at", sRiseAt, 3);chkInt("wr ready return", sReadyAt, 6);
        chkInt("wr addr/data hold", sBadHold, 0); chkInt("wr N complement", sNBad, 0);
        chkInt("wr responses", sRspCount, 0);   chkBit("wr Busy idle", busy, 1'b0);

        // Read addr=1 after write
        runTxn(1'b0, 1'b1, 1'b0, 0);
        chkInt("rd Read cycles", sRead, 5);     chkInt("rd Write cycles", sWrite, 0);
        chkInt("rd overlap", sOverlap, 0);      chkInt("rd responses", sRspCount, 1);
        chkBit("rd data", sFirstRsp, 1'b1);     chkInt("rd ready return", sReadyAt, 8);

        // Read addr=0, never written
        runTxn(1'b0, 1'b0, 1'b0, 0);
        chkInt("rd0 responses", sRspCount, 1);  chkBit("rd0 data", sFirstRsp, 1'b0);

        // Response stall for 5 cycles
        runTxn(1'b0, 1'b1, 1'b0, 5);
        chkInt("stall valid cycles", sRspCycles, 6);
        chkInt("stall data stable", sRspUnstable, 0);
        chkInt("stall ReqReady low", sReadyInRsp, 0);
        chkInt("stall release gap", sReadyAt - sRaisedAt, 1);
        chkInt("stall responses", sRspCount, 1);

        // Reset during STROBE
        hostIf.ReqWrite = 1'b0; hostIf.ReqAddr = 1'b1; hostIf.ReqValid = 1'b1;
        @(negedge DDRClockP);
        hostIf.ReqValid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (strobeP) begin seen = 1; break; end
            @(negedge DDRClockP);
        end
        chkInt("abort strobe reached", seen, 1);
        Reset = 1'b1;
        @(negedge DDRClockP);
        chkBit("abort Read", rd, 1'b0);         chkBit("abort Write", wr, 1'b0);
        chkBit("abort P", strobeP, 1'b0);       chkBit("abort N", strobeN, 1'b1);
        chkBit("abort RspValid", hostIf.RspValid, 1'b0);
        chkBit("abort ReqReady", hostIf.ReqReady, 1'b1);
        Reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge DDRClockP);
            if (hostIf.RspValid) cnt++;
        end
        chkInt("abort no response", cnt, 0);

        // Back-to-back write, read, write with ReqValid held high
        hostIf.RspReady = 1'b1;
        idx = 0; acc = 0; ovl = 0; rspCnt = 0; advance = 1'b0;
        drive5(0); hostIf.ReqValid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (rd && wr) ovl++;
            if (hostIf.RspValid && hostIf.RspReady) begin
                rspCnt++;
                popCheck("b2b rsp data", hostIf.RspData);
            end
            if (advance) begin
                advance = 1'b0;
                idx++;
                if (idx < 3) drive5(idx); else hostIf.ReqValid = 1'b0;
            end
            if (hostIf.ReqValid && hostIf.ReqReady) begin
                if (acc < 3) accAt[acc] = i;
                acc++;
                if (hostIf.ReqWrite) shadow[hostIf.ReqAddr] = hostIf.ReqData;
                else expQ.push_back(shadow[hostIf.ReqAddr]);
                advance = 1'b1;
            end
            if (idx == 3 && hostIf.ReqReady) break;
            @(negedge DDRClockP);
        end
        hostIf.RspReady = 1'b0;
        chkInt("b2b accepts", acc, 3);          chkInt("b2b responses", rspCnt, 1);
        chkInt("b2b overlap", ovl, 0);
        chkInt("b2b write turnaround", accAt[1] - accAt[0], 6);
        chkInt("b2b read turnaround", accAt[2] - accAt[1], 8);
        chkInt("scoreboard drained", expQ.size(), 0);

        // STROBE_HALF=3, SETUP skipped
        hostIf6.ReqWrite = 1'b1; hostIf6.ReqAddr = 1'b0; hostIf6.ReqData = 1'b1;
        hostIf6.ReqValid = 1'b1;
        @(negedge DDRClockP);
        hostIf6.ReqValid = 1'b0;
        rise = 0; hi = 0; fall = 0; wrc = 0; ready = 0;
        for (int i = 1; i <= 60; i++) begin
            if (wr6) wrc++;
            if (strobeP6) begin
                hi++;
                if (rise == 0) rise = i;
            end else if (rise != 0 && fall == 0) begin
                fall = i;
            end
            if (hostIf6.ReqReady) begin ready = i; break; end
            @(negedge DDRClockP);
        end
        chkInt("s3 rise at", rise, 1);          chkInt("s3 high cycles", hi, 3);
        chkInt("s3 fall at", fall, 4);          chkInt("s3 Write cycles", wrc, 7);
        chkInt("s3 ready return", ready, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
